// File: rtl/picomem_pkg.sv
// Shared definitions for the BRAM-backed PicoMem responder: state encoding
// and the base latencies that mirror the PSRAM controller's timing profile.
package picomem_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_GAP
  } state_t;

  localparam int WR_BASE = 6;
  localparam int RD_BASE = 12;

  function automatic int lat_single(input int base, input int latency);
    return base + latency;
  endfunction

  function automatic int lat_double(input int base, input int latency);
    return base + 3 * latency;
  endfunction

endpackage

// File: rtl/picomem_bram.sv
// Single-port word RAM with byte-lane write enables and a registered read
// (read-first), written so Gowin tools map it onto BSRAM.
module picomem_bram #(
  parameter int WORDS = 4096
) (
  input  logic                     clk,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [3:0]               we,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/picomem_bram_responder.sv
// PicoMem valid/ready responder backed by block RAM, emulating PSRAM init
// delay and periodic 2x latency so initiators see PSRAM-like timing.
//
// state | meaning
// INIT  | counting out the emulated PSRAM init delay
// IDLE  | waiting for valid; accept latches the request
// WAIT  | latency countdown; RAM read happens in the first cycle
// DONE  | ready pulse; strobed write lanes committed
// GAP   | one dead cycle while the initiator drops valid
module picomem_bram_responder
  import picomem_pkg::*;
#(
  parameter int ADDR_WIDTH    = 23,
  parameter int MEM_WORDS     = 4096,
  parameter int LATENCY       = 3,
  parameter int INIT_CYCLES   = 150,
  parameter int DOUBLE_PERIOD = 4
) (
  input  logic                  clk,
  input  logic                  sys_reset,
  input  logic                  valid,
  output logic                  ready,
  output logic                  init_ready,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            wstrb,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  lat_2x
);

  localparam int WORD_W = $clog2(MEM_WORDS);
  localparam int INIT_W = $clog2(INIT_CYCLES + 2);
  localparam int WAIT_W = 6;
  localparam int TX_W   = (DOUBLE_PERIOD > 1) ? $clog2(DOUBLE_PERIOD) : 1;

  // Counter loads are total latency minus the accept cycle and the DONE cycle.
  localparam logic [WAIT_W-1:0] WAIT_WR_1X = WAIT_W'(lat_single(WR_BASE, LATENCY) - 2);
  localparam logic [WAIT_W-1:0] WAIT_WR_2X = WAIT_W'(lat_double(WR_BASE, LATENCY) - 2);
  localparam logic [WAIT_W-1:0] WAIT_RD_1X = WAIT_W'(lat_single(RD_BASE, LATENCY) - 2);
  localparam logic [WAIT_W-1:0] WAIT_RD_2X = WAIT_W'(lat_double(RD_BASE, LATENCY) - 2);

  state_t              state_q, state_d;
  logic [INIT_W-1:0]   init_cnt_q;
  logic [TX_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_load;
  logic [WORD_W-1:0]   word_q;
  logic [3:0]          wstrb_q;
  logic [31:0]         wdata_q;
  logic                double_q, double_now;
  logic                accept, finish;
  logic [3:0]          ram_we;
  logic [31:0]         ram_rdata;
  logic [ADDR_WIDTH-1:0] unused_addr;

  assign unused_addr = addr;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_INIT: if (init_cnt_q == INIT_W'(INIT_CYCLES)) state_d = ST_IDLE;
      ST_IDLE: begin
        if (valid) begin
          state_d = ST_WAIT;
          accept  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = ST_DONE;
          finish  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    double_now = (DOUBLE_PERIOD != 0) && (tx_cnt_q == TX_W'(DOUBLE_PERIOD - 1));
    tx_cnt_d   = '0;
    if (DOUBLE_PERIOD != 0 && !double_now) tx_cnt_d = tx_cnt_q + 1'b1;
    if (wstrb == 4'b0000) wait_load = double_now ? WAIT_RD_2X : WAIT_RD_1X;
    else                  wait_load = double_now ? WAIT_WR_2X : WAIT_WR_1X;
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      tx_cnt_q   <= '0;
      wait_cnt_q <= '0;
      word_q     <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      double_q   <= 1'b0;
      init_ready <= 1'b0;
      ready      <= 1'b0;
      lat_2x     <= 1'b0;
      rdata      <= '0;
    end else begin
      state_q <= state_d;
      ready   <= finish;
      lat_2x  <= finish & double_q;
      if (state_q == ST_INIT) begin
        if (state_d == ST_IDLE) init_ready <= 1'b1;
        else                    init_cnt_q <= init_cnt_q + 1'b1;
      end
      if (accept) begin
        word_q     <= addr[WORD_W+1:2];
        wstrb_q    <= wstrb;
        wdata_q    <= wdata;
        wait_cnt_q <= wait_load;
        tx_cnt_q   <= tx_cnt_d;
        double_q   <= double_now;
      end else if (state_q == ST_WAIT && wait_cnt_q != '0) begin
        wait_cnt_q <= wait_cnt_q - 1'b1;
      end
      if (finish && wstrb_q == 4'b0000) rdata <= ram_rdata;
    end
  end

  assign ram_we = (state_q == ST_DONE) ? wstrb_q : 4'b0000;

  picomem_bram #(
    .WORDS (MEM_WORDS)
  ) u_bram (
    .clk   (clk),
    .addr  (word_q),
    .we    (ram_we),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: doc/picomem_bram_responder.md
# picomem_bram_responder

Block-RAM-backed responder for the PicoMem valid/ready memory bus. It has the same port contract and the same 1x/2x latency profile as the PSRAM controller, so the memory test top and future initiators can run in simulation and on-board loopback without HyperRAM. It answers single 32-bit word transactions with byte-strobed writes and emulates the PSRAM init delay and latency doubling deterministically.

## Interface
- ADDR_WIDTH, 23: byte-address width.
- MEM_WORDS, 4096: backing depth in 32-bit words; power of two.
- LATENCY, 3: emulated PSRAM latency (valid range 1..7).
- INIT_CYCLES, 150: cycles from reset release to init_ready.
- DOUBLE_PERIOD, 4: every DOUBLE_PERIOD-th accepted transaction uses 2x latency; 0 disables doubling.
- clk  in  1  single clock; all logic is on its rising edge.
- sys_reset  in  1  asynchronous reset, active high.
- valid  in  1  initiator request; held until ready.
- ready  out  1  one-cycle completion pulse.
- init_ready  out  1  high once the emulated init finishes; stays high until reset.
- addr  in  ADDR_WIDTH  byte address; bits [1:0] are ignored.
- wstrb  in  4  byte-lane write enables; 4'b0000 means read.
- wdata  in  32  write data; lane i is bits [8i+7:8i].
- rdata  out  32  read data; valid in the ready cycle and held until the next read completes.
- lat_2x  out  1  high with ready when the completing transaction used 2x latency.

## Operation
- States: INIT, IDLE, WAIT, DONE, GAP.
- Reset values: state INIT, ready 0, init_ready 0, lat_2x 0, rdata 0, init counter 0, transaction counter 0. RAM contents are not cleared.
- INIT: count INIT_CYCLES, then set init_ready and go to IDLE. valid is ignored during INIT.
- IDLE: when valid=1, latch addr, wstrb and wdata (this is the accept cycle A).
  - Word index = addr[ADDR_WIDTH-1:2] mod MEM_WORDS, so addresses wrap silently.
  - Decide 2x: the transaction counter increments on every accept and wraps at DOUBLE_PERIOD. The transaction is 2x when the pre-increment value is DOUBLE_PERIOD-1.
  - Load the wait counter and go to WAIT.
- WAIT: count down, then go to DONE.
- DONE: ready=1 for one cycle and lat_2x is set as decided.
  - Write: commit only the strobed lanes to RAM in this cycle.
  - Read: rdata takes the RAM word, which was read during WAIT.
  - Next state is GAP.
- GAP: exactly one cycle. valid is ignored, then go to IDLE. This covers the initiator's deassertion of valid after ready.
- If valid drops during WAIT, the transaction still completes: a write is committed and ready pulses.
- A read issued to a word written in the immediately preceding transaction returns the new data; the RAM write happens in DONE, well before the read sample.
- Reset asserted mid-transaction aborts it. An uncommitted write is lost, and init restarts.

## Timing
- Ready for a write arrives at A+6+LATENCY (1x) or A+6+3*LATENCY (2x).
- Ready for a read arrives at A+12+LATENCY (1x) or A+12+3*LATENCY (2x).
- The minimum gap from one ready to the next accept is 2 cycles: GAP, then IDLE sampling.
- init_ready rises INIT_CYCLES+1 cycles after sys_reset deasserts.
- RAM has 1-cycle registered read latency. Read data is fetched in the first WAIT cycle and registered before DONE.

## Structure
- Package picomem_pkg holds:
  - the state encoding;
  - the base latencies, WR_BASE=6 and RD_BASE=12;
  - the latency helpers, base+LATENCY and base+3*LATENCY.
- Sub-module picomem_bram is a single-port MEM_WORDS x 32 RAM with four byte-lane write enables and a registered read, inferable as Gowin BSRAM.

## Test plan
- **Init:** release reset, hold valid=1. Required: no ready before init_ready, init_ready rises at cycle INIT_CYCLES+1, and the first ready comes A+9 after the first IDLE (LATENCY=3, 1x write or A+15 read).
- **Byte strobes:** write 0x11776A6A with wstrb=1111 to addr 0x000010, then wstrb=0010 with 0xFFFFFFFF, then read. Required: rdata=0x1177FF6A.
- **Doubling:** with DOUBLE_PERIOD=4, run 8 reads. Required: reads 4 and 8 complete at A+21 with lat_2x=1, and the others complete at A+15 with lat_2x=0.
- **Wrap:** with MEM_WORDS=4096, write 0xDEADBEEF to addr 0x004000, then read addr 0x000000. Required: 0xDEADBEEF.
- **Valid drop:** deassert valid in cycle A+2 of a write of 0x12345678. Required: ready still pulses, and a later read returns 0x12345678.
- **Reset mid-write:** assert sys_reset at A+3 of a write of 0xCAFEF00D over 0x0BADBEEF. Required: ready, init_ready and rdata return to 0 at once, and after re-init a read returns 0x0BADBEEF.
